// File: rtl/sfifo_sync16.sv
// sfifo_sync16 -- synchronous first-word-fall-through FIFO for 16-bit host
// command words, feeding the WISHBONE SFIFO read interface (clk_500 domain).
//
// Ports:
//   wb_clk_i       clock (clk_500), rising edge
//   wb_rst_n_i     asynchronous active-low reset
//   flush_i        synchronous clear of contents (priority over wr_i/rd_i)
//   wr_i           push request
//   wr_data_i      push data
//   full_o         no free entry
//   almost_full_o  level_o >= DEPTH - AF_MARGIN
//   rd_i           pop request (one-cycle pulse from consumer)
//   rd_data_o      head word, valid whenever empty_o = 0 (async read)
//   empty_o        no stored word
//   level_o        stored word count, 0..DEPTH
//
// Optional feature, macro SFIFO_SYNC16_ERR_EN, adds:
//   ovf_o          sticky: push attempted while full with no pop
//   udf_o          sticky: pop attempted while empty
//   err_clr_i      synchronous clear of both flags (a set condition wins)
module sfifo_sync16 #(
    parameter int DW        = 16,
    parameter int AW        = 6,
    parameter int AF_MARGIN = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          flush_i,
    input  logic          wr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          full_o,
    output logic          almost_full_o,
    input  logic          rd_i,
    output logic [DW-1:0] rd_data_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
`ifdef SFIFO_SYNC16_ERR_EN
    ,
    output logic          ovf_o,
    output logic          udf_o,
    input  logic          err_clr_i
`endif
);

    localparam int          DEPTH  = 1 << AW;
    localparam logic [AW:0] AF_LVL = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        empty_q, empty_d;
    logic        full_q, full_d;
    logic        afull_q, afull_d;
    logic        push_ok, pop_ok;

    assign pop_ok  = rd_i & ~empty_q;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_ok = wr_i & (~full_q | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + ONE;
                2'b01:   level_d = level_q - ONE;
                default: level_d = level_q;
            endcase
        end
        // Flags come from next-state values so they are registered, not decoded.
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                  (wr_ptr_d[AW] != rd_ptr_d[AW]);
        afull_d = (level_d >= AF_LVL);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

    // Storage is not reset; distributed RAM with asynchronous read.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok && !flush_i) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o     = mem[rd_ptr_q[AW-1:0]];
    assign empty_o       = empty_q;
    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign level_o       = level_q;

`ifdef SFIFO_SYNC16_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Set beats clear; flush leaves the flags alone.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_i & full_q & ~pop_ok) ovf_d = 1'b1;
        if (rd_i & empty_q)          udf_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_sfifo_sync16.sv
// Randomized + directed bench for sfifo_sync16 against a queue-based model.
module tb_sfifo_sync16;

    localparam int DW = 16, AW = 6, DEPTH = 64, AFM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          full, afull, empty;
    logic [DW-1:0] rdata;
    logic [AW:0]   level;
`ifdef SFIFO_SYNC16_ERR_EN
    logic          ovf, udf, eclr = 1'b0;
`endif

    int npass = 0, ntot = 0;

    logic [DW-1:0] q [$];
    bit            m_ovf = 0, m_udf = 0;

    always #5 clk = ~clk;

    sfifo_sync16 #(.DW(DW), .AW(AW), .AF_MARGIN(AFM)) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .flush_i       (flush),
        .wr_i          (wr),
        .wr_data_i     (wdata),
        .full_o        (full),
        .almost_full_o (afull),
        .rd_i          (rd),
        .rd_data_o     (rdata),
        .empty_o       (empty),
        .level_o       (level)
`ifdef SFIFO_SYNC16_ERR_EN
        ,
        .ovf_o         (ovf),
        .udf_o         (udf),
        .err_clr_i     (eclr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".level"}, 32'(level), q.size());
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, ".afull"}, 32'(afull), 32'(q.size() >= DEPTH - AFM));
        if (q.size() != 0) chk({tag, ".head"}, 32'(rdata), 32'(q[0]));
`ifdef SFIFO_SYNC16_ERR_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
`endif
    endtask

    // One clock: drive at negedge, advance the model, check at next negedge.
    task automatic cyc(input string tag, input bit w, input logic [DW-1:0] d,
                       input bit r, input bit f, input bit c);
        bit pop_ok, push_ok, was_full, was_empty;
        wr = w; wdata = d; rd = r; flush = f;
`ifdef SFIFO_SYNC16_ERR_EN
        eclr = c;
`endif
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        pop_ok  = r && !was_empty;
        push_ok = w && (!was_full || pop_ok);
        if (w && was_full && !pop_ok) m_ovf = 1;
        else if (c)                   m_ovf = 0;
        if (r && was_empty)           m_udf = 1;
        else if (c)                   m_udf = 0;
        if (f) q.delete();
        else begin
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        wr = 0; rd = 0; flush = 0;
`ifdef SFIFO_SYNC16_ERR_EN
        eclr = 0;
`endif
        chk_all(tag);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single word latency and pop.
        cyc("push1234", 1, 16'h1234, 0, 0, 0);
        chk("first_word", 32'(rdata), 32'h1234);
        cyc("pop1", 0, 0, 1, 0, 0);

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 16'(i), 0, 0, 0);
        cyc("ovf_push", 1, 16'hBEEF, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_seq", 32'(rdata), i);
            cyc("drain", 0, 0, 1, 0, 0);
        end

        // Full with simultaneous push/pop.
        for (int i = 0; i < DEPTH; i++) cyc("fill2", 1, 16'($urandom), 0, 0, 0);
        cyc("full_rw", 1, 16'hAAAA, 1, 0, 0);
        chk("full_rw.tail", 32'(q[DEPTH-1]), 32'hAAAA);
        cyc("flush_full", 0, 0, 0, 1, 0);

        // Empty with simultaneous push/pop, then flush at level 10.
        cyc("empty_rw", 1, 16'h5A5A, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc("to10", 1, 16'($urandom), 0, 0, 0);
        cyc("flush_rw", 1, 16'hDEAD, 1, 1, 0);
        cyc("post_flush", 0, 0, 0, 0, 0);
        cyc("err_clr", 0, 0, 0, 0, 1);

        // Wrap-around at level 3.
        for (int i = 0; i < 3; i++) cyc("pre3", 1, 16'(i), 0, 0, 0);
        for (int i = 3; i < 203; i++) cyc("wrap", 1, 16'(i), 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("post3", 0, 0, 1, 0, 0);

        // Asynchronous reset mid-burst at level 20.
        for (int i = 0; i < 20; i++) cyc("burst", 1, 16'($urandom), 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        q.delete(); m_ovf = 0; m_udf = 0;
        chk_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("after_rst", 1, 16'hC0DE, 0, 0, 0);
        chk("after_rst.head", 32'(rdata), 32'hC0DE);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit w, r, f, c;
            w = ($urandom_range(99) < 55);
            r = ($urandom_range(99) < 45);
            f = ($urandom_range(199) == 0);
            c = ($urandom_range(49) == 0);
            cyc("rand", w, 16'($urandom), r, f, c);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/sfifo_sync16.md
Name: sfifo_sync16

Overview:
- Synchronous first-word-fall-through FIFO that buffers 16-bit command words from the host-side writer.
- Its read side is the source for the WISHBONE SFIFO interface: rd_data_o, empty_o and rd_i connect directly to sfifo_di, sfifo_empty_i and sfifo_rd_o of that interface.
- The whole block runs in the clk_500 domain.
- Provides full, almost-full and level status for writer back-pressure, plus a synchronous flush.

Parameters:
- DW, 16: data width; must match SFIFO_DW of the consumer.
- AW, 6: address width; DEPTH = 2**AW words (64).
- AF_MARGIN, 4: almost_full_o asserts when level_o >= DEPTH - AF_MARGIN; legal range 1..DEPTH-1.

Ports:
- wb_clk_i  in  1  clock (clk_500), rising edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of FIFO contents.
- wr_i  in  1  push request.
- wr_data_i  in  DW  push data.
- full_o  out  1  no free entry.
- almost_full_o  out  1  level at or above threshold.
- rd_i  in  1  pop request; one-cycle pulse from the consumer.
- rd_data_o  out  DW  head word, valid whenever empty_o=0.
- empty_o  out  1  no stored word.
- level_o  out  AW+1  number of stored words, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is asynchronous, active-low, on wb_rst_n_i.
- Reset values:
  - wr/rd pointers = 0, level_o = 0.
  - empty_o = 1, full_o = 0, almost_full_o = 0.
  - Error flags (optional feature) = 0.
  - Memory array is not reset. rd_data_o is don't-care while empty_o = 1.
- Pointers: wr_ptr and rd_ptr are AW+1 bits wide. The MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low AW bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2**(AW+1).
- Push accept: push_ok = wr_i & (~full_o | pop_ok). The word is written to mem[wr_ptr[AW-1:0]] and wr_ptr increments.
- Pop accept: pop_ok = rd_i & ~empty_o. rd_ptr increments.
- Read port: rd_data_o = mem[rd_ptr[AW-1:0]], asynchronous read (distributed RAM).
  - The head word is therefore stable from the cycle empty_o falls until the cycle after pop_ok.
- Latency: a word pushed at edge N sets empty_o=0 and appears on rd_data_o after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Boundary cases:
  - Simultaneous push and pop when empty: push accepted, pop ignored. Level goes 0 -> 1.
  - Simultaneous push and pop when full: both accepted. Level stays DEPTH and full_o stays 1.
  - Simultaneous push and pop otherwise: both accepted, level unchanged.
  - Push while full with no pop: dropped. Pointers and contents unchanged.
  - Pop while empty: ignored.
- Level update: level_o is registered and updates in the same edge as the pointers: +1 push only, -1 pop only, 0 for both or neither.
- Status flags: full_o, empty_o and almost_full_o are registered, derived from the next-state pointers/level, so they are valid in the cycle after the causing edge.
- Flush: flush_i=1 at an edge sets both pointers to 0, level_o=0, empty_o=1, full_o=0, almost_full_o=0.
  - Flush has priority over wr_i and rd_i in the same cycle; both are ignored.
  - Error flags are not cleared by flush.
- Reset mid-operation: asynchronous reset returns all state to reset values immediately. The first push after reset release writes entry 0.

Optional Feature:
- Macro: SFIFO_SYNC16_ERR_EN.
- Defined: adds the following ports.
  - ovf_o (out, 1): sticky; set on any cycle with wr_i & full_o & ~pop_ok.
  - udf_o (out, 1): sticky; set on any cycle with rd_i & empty_o.
  - err_clr_i (in, 1): synchronous clear of both flags. A set condition in the same cycle wins over the clear.
  - Both flags reset to 0.
- Not defined: these ports and registers are absent. Dropped pushes and ignored pops leave no trace. FIFO behaviour is otherwise identical.

Test Plan:
- Reset release, push 0x1234 in one cycle -> next cycle: empty_o=0, rd_data_o=0x1234, level_o=1. Pulse rd_i -> next cycle: empty_o=1, level_o=0.
- Push 64 words 0x0000..0x003F -> almost_full_o rises as level_o reaches 60, full_o=1 at level 64. Then:
  - Extra push 0xBEEF -> dropped; ovf_o=1 when ERR_EN.
  - Pop all 64 -> read sequence is exactly 0x0000..0x003F.
- Wrap-around: run 200 push/pop pairs at level 3 with incrementing data -> output order is preserved across pointer wrap, and level_o stays 3 throughout.
- Full with simultaneous wr_i=1 (0xAAAA) and rd_i=1 -> head popped, 0xAAAA stored, full_o stays 1. Empty with simultaneous wr_i and rd_i -> level_o=1, and udf_o=1 when ERR_EN.
- flush_i asserted together with wr_i and rd_i at level 10 -> next cycle: level_o=0, empty_o=1, nothing written. Error flags are retained until err_clr_i.
- Assert wb_rst_n_i low asynchronously mid-burst at level 20 -> outputs reach reset values before the next clock edge. After release, the first pushed word is the first word read.
